// File: rtl/tlb_multiport.sv
// tlb_multiport: multi-port joint TLB with registered lookups, flush engine and Random index.
// Entry word, MSB first: vpn2, asid, g, {pfn0,c0,d0,v0}, {pfn1,c1,d1,v1}.
module tlb_multiport #(
   parameter  int TLB_NUM  = 16,
   parameter  int PORT_NUM = 3,
   localparam int IDX_W    = $clog2(TLB_NUM),
   localparam int ENTRY_W  = 78
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [PORT_NUM-1:0]       search_valid,
   input  logic [PORT_NUM*19-1:0]    search_vpn2,
   input  logic [PORT_NUM-1:0]       search_odd,
   input  logic [PORT_NUM*8-1:0]     search_asid,
   output logic [PORT_NUM-1:0]       result_valid,
   output logic [PORT_NUM-1:0]       result_found,
   output logic [PORT_NUM-1:0]       result_multi,
   output logic [PORT_NUM*IDX_W-1:0] result_index,
   output logic [PORT_NUM*20-1:0]    result_pfn,
   output logic [PORT_NUM*3-1:0]     result_c,
   output logic [PORT_NUM-1:0]       result_d,
   output logic [PORT_NUM-1:0]       result_v,
   input  logic                      write_en,
   input  logic                      write_random,
   input  logic [IDX_W-1:0]          write_index,
   input  logic [ENTRY_W-1:0]        write_data,
   output logic                      write_ready,
   input  logic [IDX_W-1:0]          read_index,
   output logic [ENTRY_W-1:0]        read_data,
   output logic                      read_entry_valid,
   input  logic [IDX_W-1:0]          wired,
   input  logic                      wired_we,
   output logic [IDX_W-1:0]          random,
   input  logic                      flush_req,
   input  logic                      flush_by_asid,
   input  logic [7:0]                flush_asid,
   output logic                      busy
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(TLB_NUM - 1);
   localparam int PG_W = 25;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          fc_q, fc_d;
   logic                      mode_q, mode_d;
   logic [7:0]                fasid_q, fasid_d;
   logic [IDX_W-1:0]          rnd_q, rnd_d;
   logic [ENTRY_W-1:0]        entry_q [TLB_NUM];
   logic [TLB_NUM-1:0]        valid_q, valid_d;
   logic                      flushing, clr, wr_go;
   logic [IDX_W-1:0]          wr_idx;
   logic [PORT_NUM-1:0]       res_valid_q, found_q, found_d, multi_q, multi_d;
   logic [PORT_NUM*IDX_W-1:0] index_q, index_d;
   logic [PORT_NUM*PG_W-1:0]  page_q, page_d;
   logic [ENTRY_W-1:0]        sel, read_data_q;
   logic                      read_valid_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FLUSH;
         fc_q    <= '0;
         mode_q  <= 1'b0;
         fasid_q <= '0;
      end else begin
         state_q <= state_d;
         fc_q    <= fc_d;
         mode_q  <= mode_d;
         fasid_q <= fasid_d;
      end
   end

   always_comb begin
      state_d = state_q == IDLE ? (flush_req ? FLUSH : IDLE) : (fc_q == LAST ? IDLE : FLUSH);
      fc_d    = state_q == IDLE ? '0 : fc_q + 1'b1;
      mode_d  = state_q == IDLE && flush_req ? flush_by_asid : mode_q;
      fasid_d = state_q == IDLE && flush_req ? flush_asid : fasid_q;
   end

   // Selective mode spares global entries and entries of other address spaces.
   always_comb begin
      flushing = state_q == FLUSH;
      clr      = flushing && (!mode_q || (!entry_q[fc_q][50] && entry_q[fc_q][58:51] == fasid_q));
   end

   assign wr_go  = write_en && !flushing;
   assign wr_idx = write_random ? rnd_q : write_index;
   assign rnd_d  = (wired_we || rnd_q <= wired) ? LAST : rnd_q - 1'b1;

   always_comb begin
      valid_d = valid_q;
      if (clr) valid_d[fc_q] = 1'b0;
      if (wr_go) valid_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (wr_go) entry_q[wr_idx] <= write_data;
   end

   // Lowest matching index wins; a second match only raises the multi-hit flag.
   always_comb begin
      found_d = '0;
      multi_d = '0;
      index_d = '0;
      page_d  = '0;
      sel     = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         for (int i = 0; i < TLB_NUM; i++) begin
            if (search_valid[p] && !flushing && valid_q[i] &&
                entry_q[i][77:59] == search_vpn2[p*19 +: 19] &&
                (entry_q[i][50] || entry_q[i][58:51] == search_asid[p*8 +: 8])) begin
               multi_d[p] = multi_d[p] | found_d[p];
               if (!found_d[p]) index_d[p*IDX_W +: IDX_W] = IDX_W'(i);
               found_d[p] = 1'b1;
            end
         end
         sel = entry_q[index_d[p*IDX_W +: IDX_W]];
         if (found_d[p]) page_d[p*PG_W +: PG_W] = search_odd[p] ? sel[PG_W-1:0] : sel[2*PG_W-1:PG_W];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rnd_q        <= LAST;
         valid_q      <= '0;
         res_valid_q  <= '0;
         found_q      <= '0;
         multi_q      <= '0;
         index_q      <= '0;
         page_q       <= '0;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
      end else begin
         rnd_q        <= rnd_d;
         valid_q      <= valid_d;
         res_valid_q  <= search_valid;
         found_q      <= found_d;
         multi_q      <= multi_d;
         index_q      <= index_d;
         page_q       <= page_d;
         read_data_q  <= entry_q[read_index];
         read_valid_q <= valid_q[read_index];
      end
   end

   for (genvar k = 0; k < PORT_NUM; k++) begin : g_port
      assign result_pfn[k*20 +: 20] = page_q[k*PG_W+5 +: 20];
      assign result_c[k*3 +: 3]     = page_q[k*PG_W+2 +: 3];
      assign result_d[k]            = page_q[k*PG_W+1];
      assign result_v[k]            = page_q[k*PG_W];
   end

   assign result_valid     = res_valid_q;
   assign result_found     = found_q;
   assign result_multi     = multi_q;
   assign result_index     = index_q;
   assign read_data        = read_data_q;
   assign read_entry_valid = read_valid_q;
   assign random           = rnd_q;
   assign busy             = flushing;
   assign write_ready      = !flushing;
endmodule

// File: tb/tb_tlb_multiport.sv
// tb_tlb_multiport: randomized and directed checks of tlb_multiport against a behavioural TLB model.
module tb_tlb_multiport;
   localparam int N = 16, P = 3, IW = 4, EW = 78;

   logic clock = 1'b0, reset_n = 1'b1;
   always #5 clock = ~clock;

   logic [P-1:0]    search_valid = '0, search_odd = '0;
   logic [P*19-1:0] search_vpn2 = '0;
   logic [P*8-1:0]  search_asid = '0;
   logic [P-1:0]    result_valid, result_found, result_multi, result_d, result_v;
   logic [P*IW-1:0] result_index;
   logic [P*20-1:0] result_pfn;
   logic [P*3-1:0]  result_c;
   logic            write_en = 1'b0, write_random = 1'b0, write_ready;
   logic [IW-1:0]   write_index = '0, read_index = '0, wired = '0, random;
   logic [EW-1:0]   write_data = '0, read_data;
   logic            read_entry_valid, wired_we = 1'b0, flush_req = 1'b0, flush_by_asid = 1'b0, busy;
   logic [7:0]      flush_asid = '0;

   tlb_multiport #(.TLB_NUM(N), .PORT_NUM(P)) dut (
      .clock(clock), .reset_n(reset_n),
      .search_valid(search_valid), .search_vpn2(search_vpn2), .search_odd(search_odd), .search_asid(search_asid),
      .result_valid(result_valid), .result_found(result_found), .result_multi(result_multi),
      .result_index(result_index), .result_pfn(result_pfn), .result_c(result_c),
      .result_d(result_d), .result_v(result_v),
      .write_en(write_en), .write_random(write_random), .write_index(write_index), .write_data(write_data),
      .write_ready(write_ready), .read_index(read_index), .read_data(read_data),
      .read_entry_valid(read_entry_valid), .wired(wired), .wired_we(wired_we), .random(random),
      .flush_req(flush_req), .flush_by_asid(flush_by_asid), .flush_asid(flush_asid), .busy(busy)
   );

   int checks = 0, failures = 0;

   // Reference TLB: flat arrays plus a remaining-cycles flush counter.
   bit [EW-1:0] m_entry [N];
   bit          m_valid [N];
   bit          m_wr [N];
   int          m_rnd, fl_cnt, fl_pos;
   bit          fl_sel;
   bit [7:0]    fl_asid;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [18:0] v, input logic [7:0] a, input logic g,
                                        input logic [19:0] p0, input logic [4:0] a0,
                                        input logic [19:0] p1, input logic [4:0] a1);
      return {v, a, g, p0, a0, p1, a1};
   endfunction

   task automatic setp(input int p, input logic [18:0] v, input logic odd, input logic [7:0] a);
      search_valid[p]         = 1'b1;
      search_vpn2[p*19 +: 19] = v;
      search_odd[p]           = odd;
      search_asid[p*8 +: 8]   = a;
   endtask

   task automatic step();
      bit              busy_m;
      int              cnt, wi;
      logic [P-1:0]    ev, ef, em;
      logic [IW-1:0]   ei [P];
      logic [24:0]     epg [P];
      logic [EW-1:0]   erd;
      bit              erv, erw;
      busy_m = fl_cnt > 0;
      ev = search_valid;
      for (int p = 0; p < P; p++) begin
         cnt = 0; ei[p] = '0; epg[p] = '0;
         if (search_valid[p] && !busy_m)
            for (int i = 0; i < N; i++)
               if (m_valid[i] && m_entry[i][77:59] == search_vpn2[p*19 +: 19] &&
                   (m_entry[i][50] || m_entry[i][58:51] == search_asid[p*8 +: 8])) begin
                  if (cnt == 0) ei[p] = IW'(i);
                  cnt++;
               end
         ef[p] = cnt > 0;
         em[p] = cnt > 1;
         if (ef[p]) epg[p] = search_odd[p] ? m_entry[ei[p]][24:0] : m_entry[ei[p]][49:25];
      end
      erd = m_entry[read_index]; erv = m_valid[read_index]; erw = m_wr[read_index];
      wi = write_random ? m_rnd : int'(write_index);
      if (busy_m) begin
         if (!fl_sel || (!m_entry[fl_pos][50] && m_entry[fl_pos][58:51] == fl_asid)) m_valid[fl_pos] = 0;
         fl_pos++; fl_cnt--;
      end else begin
         if (write_en) begin m_entry[wi] = write_data; m_valid[wi] = 1; m_wr[wi] = 1; end
         if (flush_req) begin fl_cnt = N; fl_pos = 0; fl_sel = flush_by_asid; fl_asid = flush_asid; end
      end
      m_rnd = (wired_we || m_rnd <= int'(wired)) ? N - 1 : m_rnd - 1;
      @(posedge clock); #1;
      for (int p = 0; p < P; p++) begin
         check($sformatf("valid%0d", p), result_valid[p], ev[p]);
         check($sformatf("found%0d", p), result_found[p], ef[p]);
         check($sformatf("multi%0d", p), result_multi[p], em[p]);
         check($sformatf("index%0d", p), result_index[p*IW +: IW], ei[p]);
         check($sformatf("pfn%0d", p), result_pfn[p*20 +: 20], epg[p][24:5]);
         check($sformatf("c%0d", p), result_c[p*3 +: 3], epg[p][4:2]);
         check($sformatf("d%0d", p), result_d[p], epg[p][1]);
         check($sformatf("v%0d", p), result_v[p], epg[p][0]);
      end
      check("read_valid", read_entry_valid, erv);
      if (erw) check("read_data", read_data, erd);
      check("random", random, m_rnd);
      check("busy", busy, fl_cnt > 0);
      check("write_ready", write_ready, fl_cnt == 0);
      write_en = 0; write_random = 0; flush_req = 0; wired_we = 0; search_valid = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_rnd = N - 1; fl_cnt = N; fl_pos = 0; fl_sel = 0; fl_asid = '0;
      check("rst_result", {result_valid, result_found, result_multi, result_index}, '0);
      check("rst_page", {result_pfn, result_c, result_d, result_v}, '0);
      check("rst_read", {read_entry_valid, read_data}, '0);
      check("rst_random", random, N - 1);
      check("rst_busy", {busy, write_ready}, 2'b10);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   logic [EW-1:0] d3, tw;
   int w;

   initial begin
      #2;
      do_reset();
      // reset flush: lookups miss, writes are dropped
      for (int k = 0; k < N; k++) begin
         setp(0, 19'h12345, 1'b0, 8'h3);
         write_en = k == 3; write_index = 4'd0; write_data = mk(19'h12345, 8'h3, 1'b1, 20'h1, 5'h1, 20'h2, 5'h1);
         step();
      end
      check("flush_done", busy, 1'b0);
      // basic hit
      write_en = 1; write_index = 4'd5; write_data = mk(19'h12345, 8'h3, 1'b0, 20'h0, 5'h0, 20'hABCDE, 5'b01101);
      step();
      setp(1, 19'h12345, 1'b1, 8'h3);
      step();
      check("hit_found", result_found[1], 1'b1);
      check("hit_index", result_index[IW +: IW], 4'd5);
      check("hit_pfn", result_pfn[20 +: 20], 20'hABCDE);
      check("hit_v", result_v[1], 1'b1);
      setp(1, 19'h12345, 1'b1, 8'h4);
      step();
      check("asid_miss", result_found[1], 1'b0);
      // multi-hit on a global vpn2
      write_en = 1; write_index = 4'd2; write_data = mk(19'h00777, 8'h9, 1'b1, 20'h11111, 5'h3, 20'h0, 5'h0);
      step();
      write_en = 1; write_index = 4'd9; write_data = mk(19'h00777, 8'h5, 1'b1, 20'h22222, 5'h3, 20'h0, 5'h0);
      step();
      setp(0, 19'h00777, 1'b0, 8'h1);
      step();
      check("multi_flag", result_multi[0], 1'b1);
      check("multi_index", result_index[0 +: IW], 4'd2);
      check("multi_pfn", result_pfn[0 +: 20], 20'h11111);
      // random counter with wired = 4
      wired = 4'd4; wired_we = 1;
      step();
      check("rnd_start", random, 15);
      for (int k = 1; k <= 11; k++) begin
         step();
         check("rnd_seq", random, 15 - k);
      end
      step();
      check("rnd_wrap", random, 15);
      repeat (3) step();
      wired_we = 1;
      step();
      check("rnd_wired_we", random, 15);
      repeat (2) step();
      w = m_rnd;
      tw = mk(19'h0ABCD, 8'h7, 1'b0, 20'h33333, 5'h1F, 20'h44444, 5'h1F);
      write_en = 1; write_random = 1; write_data = tw;
      step();
      read_index = IW'(w);
      step();
      check("tlbwr_data", read_data, tw);
      check("tlbwr_valid", read_entry_valid, 1'b1);
      // selective flush of ASID 1, entry 4 is a global ASID-1 entry
      for (int i = 0; i < 8; i++) begin
         write_en = 1; write_index = IW'(i);
         write_data = mk(19'h100 + 19'(i), 8'((i % 2) + 1), i == 4, 20'(i), 5'h1, 20'(i + 16), 5'h1);
         if (i == 3) d3 = write_data;
         step();
      end
      flush_req = 1; flush_by_asid = 1; flush_asid = 8'h1;
      step();
      for (int k = 0; k < N; k++) begin
         write_en = k == 5; write_index = 4'd3; write_data = mk(19'h7FFFF, 8'h1, 1'b0, 20'h0, 5'h0, 20'h0, 5'h0);
         setp(2, 19'h101, 1'b0, 8'h2);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         read_index = IW'(i);
         step();
         check($sformatf("sel_valid%0d", i), read_entry_valid, !(i % 2 == 0 && i != 4));
      end
      read_index = 4'd3;
      step();
      check("drop_write", read_data, d3);
      // concurrency: write to a searched entry
      for (int i = 0; i < 3; i++) begin
         write_en = 1; write_index = IW'(10 + i);
         write_data = mk(19'h500 + 19'(i), 8'h0, 1'b1, 20'h5000 + 20'(i), 5'h1, 20'h6000 + 20'(i), 5'h1);
         step();
      end
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < P; p++) setp(p, 19'h500 + 19'(p), 1'b0, 8'h2);
         write_en = c == 0; write_index = 4'd11; write_data = mk(19'h501, 8'h0, 1'b1, 20'hBEEF0, 5'h1, 20'h0, 5'h0);
         step();
         check("conc_pfn", result_pfn[20 +: 20], c == 0 ? 20'h5001 : 20'hBEEF0);
      end
      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         for (int p = 0; p < P; p++)
            if ($urandom_range(0, 3) != 0) setp(p, 19'h500 + 19'($urandom_range(0, 7)), 1'($urandom), 8'($urandom_range(1, 3)));
         write_en = $urandom_range(0, 9) < 3; write_random = 1'($urandom); write_index = IW'($urandom);
         write_data = mk(19'h500 + 19'($urandom_range(0, 7)), 8'($urandom_range(1, 3)), $urandom_range(0, 3) == 0,
                         20'($urandom), 5'($urandom), 20'($urandom), 5'($urandom));
         read_index = IW'($urandom);
         if ($urandom_range(0, 19) == 0) begin wired = IW'($urandom); wired_we = 1'($urandom); end
         flush_req = $urandom_range(0, 49) == 0; flush_by_asid = 1'($urandom); flush_asid = 8'($urandom_range(1, 3));
         step();
      end
      // reset in the middle of a flush restarts a full flush
      flush_req = 1; flush_by_asid = 1; flush_asid = 8'h2;
      step();
      repeat (5) step();
      do_reset();
      for (int k = 0; k < N + 4; k++) begin
         for (int p = 0; p < P; p++) setp(p, 19'h500 + 19'(p), 1'b0, 8'h1);
         read_index = IW'(k);
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
